// File: rtl/button_pkg.sv
// Shared types and constants for the pushbutton front end: event kinds,
// per-button tracker states and the millisecond counter width.
package button_pkg;

  localparam int MS_CNT_W = 16;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } ev_kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } btn_state_t;

  // Millisecond counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [MS_CNT_W-1:0] ms_sat_inc(input logic [MS_CNT_W-1:0] value);
    logic [MS_CNT_W-1:0] result;
    if (value == {MS_CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + MS_CNT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/button_tracker.sv
// Per-button press/hold tracker: raises a one-cycle event strobe plus its kind.
// REPEAT events are produced only when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
module button_tracker
  import button_pkg::*;
#(
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick,
  input  logic     level,
  input  logic     level_q,
  output logic     ev,
  output ev_kind_t kind
);

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam logic [MS_CNT_W-1:0] LONG_CNT = MS_CNT_W'(LONG_MS);
  localparam logic [MS_CNT_W-1:0] REP_CNT  = MS_CNT_W'(REPEAT_MS);

  btn_state_t          state_r, state_s;
  logic [MS_CNT_W-1:0] cnt_r, cnt_s;

  // State and millisecond counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state and event strobe; a release is checked first so it masks LONG/REPEAT.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ev      = 1'b0;
    kind    = EV_PRESS;
    case (state_r)
      IDLE: begin
        // Requiring the registered copy low lets a button held through reset report PRESS.
        if (level && !level_q) begin
          ev      = 1'b1;
          kind    = EV_PRESS;
          cnt_s   = '0;
          state_s = DOWN;
        end else begin
          state_s = IDLE;
        end
      end
      DOWN: begin
        if (!level) begin
          ev      = 1'b1;
          kind    = EV_RELEASE;
          state_s = IDLE;
        end else if (cnt_r == LONG_CNT) begin
          ev      = 1'b1;
          kind    = EV_LONG;
          cnt_s   = '0;
          state_s = HELD;
        end else if (tick) begin
          cnt_s = ms_sat_inc(cnt_r);
        end else begin
          cnt_s = cnt_r;
        end
      end
      HELD: begin
        if (!level) begin
          ev      = 1'b1;
          kind    = EV_RELEASE;
          state_s = IDLE;
        end else if (REPEAT_EN && (cnt_r == REP_CNT)) begin
          ev    = 1'b1;
          kind  = EV_REPEAT;
          cnt_s = '0;
        end else if (tick) begin
          cnt_s = ms_sat_inc(cnt_r);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

endmodule

// File: rtl/debounce.sv
// Single-button debouncer: two-flop synchroniser plus a stability counter.
// Internals are deliberately not reset so a held button survives a system reset.
module debounce #(
  parameter int CLOCK_RATE_HZ = 16_000_000,
  parameter int SLOW_RATE_HZ  = 1_000_000
) (
  input  logic clk,
  input  logic btn,
  output logic level
);

  localparam int RATIO  = CLOCK_RATE_HZ / SLOW_RATE_HZ;
  localparam int THRESH = (RATIO < 2) ? 2 : RATIO;
  localparam int CNT_W  = $clog2(THRESH + 1);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] stable_cnt_r;

  // Synchronise the raw level, then accept it only after THRESH consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    sync_r <= {sync_r[0], btn};
    if (sync_r[1] == level) begin
      stable_cnt_r <= '0;
      level        <= level;
    end else if (stable_cnt_r >= CNT_W'(THRESH - 1)) begin
      stable_cnt_r <= '0;
      level        <= sync_r[1];
    end else begin
      stable_cnt_r <= stable_cnt_r + CNT_W'(1);
      level        <= level;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Pushbutton front end: debouncers, per-button trackers, one-deep pending slots and a
// round-robin arbiter onto a valid/ready event stream. Option: BUTTON_EVENT_AUTO_REPEAT_EN.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int NUM_BTN          = 4,
  parameter int CLOCK_RATE_HZ    = 16_000_000,
  parameter int DEBOUNCE_RATE_HZ = 1_000_000,
  parameter int LONG_MS          = 500,
  parameter int REPEAT_MS        = 100,
  localparam int ID_W            = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic               o_ev_valid,
  input  logic               i_ev_ready,
  output logic [ID_W-1:0]    o_ev_id,
  output logic [1:0]         o_ev_kind,
  output logic [NUM_BTN-1:0] o_btn_state,
  output logic               o_overflow
);

  localparam int TICK_DIV = (CLOCK_RATE_HZ / 1000 < 1) ? 1 : CLOCK_RATE_HZ / 1000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]   pre_r;
  logic               ms_tick_s;
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] ev_s;
  ev_kind_t           ev_kind_s [NUM_BTN];
  logic [NUM_BTN-1:0] slot_vld_r;
  ev_kind_t           slot_kind_r [NUM_BTN];
  logic [ID_W-1:0]    ptr_r;
  logic [ID_W:0]      sum_s;
  logic [ID_W-1:0]    scan_s;
  logic               gnt_found_s;
  logic [ID_W-1:0]    gnt_idx_s;
  ev_kind_t           gnt_kind_s;
  logic [ID_W-1:0]    ptr_nx_s;
  logic               load_s;
  logic               grant_s;
  logic [NUM_BTN-1:0] take_s;
  logic [NUM_BTN-1:0] drop_s;

  // Free-running millisecond prescaler, restarted by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_r <= '0;
    end else if (ms_tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  assign ms_tick_s = (pre_r == PRE_W'(TICK_DIV - 1));

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce #(
      .CLOCK_RATE_HZ(CLOCK_RATE_HZ),
      .SLOW_RATE_HZ (DEBOUNCE_RATE_HZ)
    ) u_debounce (
      .clk  (i_clk),
      .btn  (i_btn[g]),
      .level(level_s[g])
    );

    button_tracker #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_tracker (
      .clk    (i_clk),
      .reset  (i_reset),
      .tick   (ms_tick_s),
      .level  (level_s[g]),
      .level_q(o_btn_state[g]),
      .ev     (ev_s[g]),
      .kind   (ev_kind_s[g])
    );
  end

  // Registered copy of the debounced levels; also the trackers' edge reference.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_btn_state <= '0;
    end else begin
      o_btn_state <= level_s;
    end
  end

  // Round-robin scan: first pending slot at or after the pointer, wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    gnt_kind_s  = EV_PRESS;
    sum_s       = '0;
    scan_s      = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      sum_s  = {1'b0, ptr_r} + (ID_W+1)'(k);
      scan_s = (sum_s >= (ID_W+1)'(NUM_BTN)) ? ID_W'(sum_s - (ID_W+1)'(NUM_BTN))
                                             : sum_s[ID_W-1:0];
      if (!gnt_found_s && slot_vld_r[scan_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = scan_s;
        gnt_kind_s  = slot_kind_r[scan_s];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign load_s   = !o_ev_valid || i_ev_ready;
  assign grant_s  = load_s && gnt_found_s;
  assign ptr_nx_s = (gnt_idx_s == ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx_s + ID_W'(1);

  // One-hot view of the slot being emptied this cycle, and of events that find no room.
  always_comb begin
    take_s = '0;
    if (grant_s) begin
      take_s[gnt_idx_s] = 1'b1;
    end else begin
      take_s = '0;
    end
    drop_s = ev_s & slot_vld_r & ~take_s;
  end

  // Pending slots: a slot being granted this cycle may accept a new event at once.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slot_vld_r <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        slot_kind_r[i] <= EV_PRESS;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (ev_s[i] && (!slot_vld_r[i] || take_s[i])) begin
          slot_vld_r[i]  <= 1'b1;
          slot_kind_r[i] <= ev_kind_s[i];
        end else if (take_s[i]) begin
          slot_vld_r[i]  <= 1'b0;
          slot_kind_r[i] <= slot_kind_r[i];
        end else begin
          slot_vld_r[i]  <= slot_vld_r[i];
          slot_kind_r[i] <= slot_kind_r[i];
        end
      end
    end
  end

  // Sticky overflow, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_overflow <= 1'b0;
    end else if (|drop_s) begin
      o_overflow <= 1'b1;
    end else begin
      o_overflow <= o_overflow;
    end
  end

  // Output register: reloads when empty or on a handshake, so events can stream back to back.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ev_valid <= 1'b0;
      o_ev_id    <= '0;
      o_ev_kind  <= 2'd0;
      ptr_r      <= '0;
    end else if (load_s) begin
      if (gnt_found_s) begin
        o_ev_valid <= 1'b1;
        o_ev_id    <= gnt_idx_s;
        o_ev_kind  <= gnt_kind_s;
        ptr_r      <= ptr_nx_s;
      end else begin
        o_ev_valid <= 1'b0;
        o_ev_id    <= o_ev_id;
        o_ev_kind  <= o_ev_kind;
        ptr_r      <= ptr_r;
      end
    end else begin
      o_ev_valid <= o_ev_valid;
      o_ev_id    <= o_ev_id;
      o_ev_kind  <= o_ev_kind;
      ptr_r      <= ptr_r;
    end
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Front-end controller for all board pushbuttons.
- Instantiates one debouncer per raw button and tracks per-button press/hold state.
- Generates PRESS, RELEASE, LONG and REPEAT events.
- Round-robin arbitrates them onto one valid/ready event stream consumed by the UART/LED logic.

Parameters:
- NUM_BTN, 4: number of buttons (1..8).
- CLOCK_RATE_HZ, 16_000_000: system clock frequency.
- DEBOUNCE_RATE_HZ, 1_000_000: sample rate passed to debounce as SLOW_RATE_HZ.
- LONG_MS, 500: hold time in ms before LONG fires.
- REPEAT_MS, 100: REPEAT period in ms after LONG (used only with the optional feature).

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: synchronous, active-high reset.
- i_btn, input, NUM_BTN: raw button levels, asynchronous to i_clk.
- o_ev_valid, output, 1: event available.
- i_ev_ready, input, 1: consumer accepts the event.
- o_ev_id, output, clog2(NUM_BTN) (min 1): button index of the event.
- o_ev_kind, output, 2: 0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
- o_btn_state, output, NUM_BTN: registered debounced levels.
- o_overflow, output, 1: sticky flag; an event was dropped.

Behaviour:
- Reset values: o_ev_valid = 0, o_ev_id = 0, o_ev_kind = 0, o_btn_state = 0, o_overflow = 0. All per-button FSMs go to IDLE, pending slots clear, RR pointer = 0, ms prescaler = 0.
- Debouncer internals are not reset. A button held through reset produces a PRESS once its debounced level is seen high after reset.
- ms tick: one-cycle pulse every CLOCK_RATE_HZ/1000 cycles from a free-running prescaler. Prescaler restarts at 0 on reset.
- Per-button FSM, driven by debounced level d, registered copy p (= o_btn_state) and a 16-bit ms counter:
  - IDLE: on d = 1 and p = 0, raise PRESS, clear counter, go to DOWN.
  - DOWN: counter increments on each tick. When counter reaches LONG_MS, raise LONG, clear counter, go to HELD. On d = 0, raise RELEASE, go to IDLE.
  - HELD: on d = 0, raise RELEASE, go to IDLE. Otherwise the counter saturates at 0xFFFF.
  - A release takes priority over LONG raised in the same cycle; LONG is suppressed.
- Pending slot: one entry per button (valid bit + kind), written in the cycle after the debounced edge.
  - If the slot is occupied and not being granted that cycle, the new event is dropped and o_overflow sets. o_overflow clears only on reset.
  - If the slot is being granted in the same cycle, the new event is written (no drop).
- Arbiter: the output register loads when o_ev_valid = 0, or when o_ev_valid = 1 and i_ev_ready = 1 (back-to-back events with no bubble).
  - Grant goes to the first pending slot at or after the RR pointer, wrapping at NUM_BTN-1 -> 0.
  - The pointer moves to the granted index + 1 (wraps).
  - With no pending slots, o_ev_valid drops after a handshake.
- Output stability: while o_ev_valid = 1 and i_ev_ready = 0, o_ev_id and o_ev_kind are held stable.
- Latency: debounced edge at cycle t -> slot valid at t+1 -> o_ev_valid at t+2 when the output register is free.
- Reset mid-handshake: the event in flight is discarded and no partial state survives.

Optional Feature:
- Macro: BUTTON_EVENT_AUTO_REPEAT_EN.
- Defined: in HELD, the counter clears and REPEAT is raised every REPEAT_MS ticks until release. Repeats follow the same slot/overflow rules.
- Undefined: HELD raises nothing further, kind 3 is never emitted, and REPEAT_MS is unused.

Decomposition:
- Shared package button_pkg holds:
  - ev_kind_t enum: EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT.
  - btn_state_t enum: IDLE, DOWN, HELD.
  - MS_CNT_W = 16.
- Natural sub-module: button_tracker (one per button: FSM, ms counter, raises an event strobe + kind). Instantiated in a generate loop next to the existing debounce instances.
- Arbiter, prescaler and output register stay in the top.

Test Plan (sim params: CLOCK_RATE_HZ = 16000, DEBOUNCE_RATE_HZ = 1000, LONG_MS = 4, REPEAT_MS = 2; debounce threshold 16 cycles, ms tick every 16 cycles):
- Button 2 held high for 40 cycles then low, i_ev_ready = 1 -> exactly (id 2, PRESS) then (id 2, RELEASE); no LONG; o_overflow = 0.
- Button 0 held for 120 cycles -> PRESS, then LONG about 4 ticks (64 cycles) later, then RELEASE. With the macro: REPEATs every 32 cycles between LONG and RELEASE.
- Buttons 0 and 3 pressed in the same cycle, ready = 1 -> id 0 then id 3 on consecutive cycles. A following simultaneous pair is granted id 3's neighbour first per the RR pointer (pointer = 0 after id 3 -> id 0 first).
- i_ev_ready = 0 with button 1 press then release -> o_ev_valid stays high with id 1 / PRESS held stable; RELEASE is queued in the slot; a second press while RELEASE is still pending sets o_overflow. Raising ready drains PRESS, RELEASE.
- Glitch: button 1 toggled every 5 cycles for 100 cycles -> no events emitted.
- i_reset asserted while o_ev_valid = 1 -> the next cycle shows all outputs 0. With the button still held, a new PRESS appears after release from reset.
